sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO: storage array plus control in one clock domain. Successor to the fixed 8x8 pointer/gap controller.
- Adds: configurable width and depth, data path, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow errors, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer blocks as the team's general-purpose rate/burst buffer.

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/fifo_ram.sv | 35 +++
 rtl/sync_fifo_param.sv | 151 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: pointer/count width
// arithmetic and the legality rules for the configuration parameters.
package fifo_pkg;

  // Ceiling log2 for elaboration-time width derivation (value >= 1).
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Occupancy needs one more bit than the pointers so that DEPTH is representable.
  function automatic int cnt_w_f(input int depth);
    return clog2_f(depth) + 1;
  endfunction

  // Depth must be a power of two so pointers wrap by plain overflow.
  function automatic bit is_pow2_f(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  // Almost-full threshold must be reachable and non-trivial: 1..depth.
  function automatic bit af_legal_f(input int depth, input int af_level);
    return (af_level >= 1) && (af_level <= depth);
  endfunction

  // Almost-empty threshold must lie in 0..depth-1.
  function automatic bit ae_legal_f(input int depth, input int ae_level);
    return (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: one synchronous write port and one read
// port that is either asynchronous or registered, chosen by REG_RD.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = clog2_f(DEPTH),
  parameter int REG_RD = 0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (REG_RD != 0) begin : g_reg_rd
    // Registered read: data appears one edge after the address.
    always_ff @(posedge clk) begin
      rdata <= mem[raddr];
    end
  end else begin : g_async_rd
    assign rdata = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow errors and
// a selectable standard (latency-1) or first-word-fall-through read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  parameter  int FWFT     = 0,
  localparam int PTR_W    = clog2_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int CNT_W = cnt_w_f(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  // Configuration legality, rejected at elaboration.
  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_W must be at least 1");
  end
  if (!is_pow2_f(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (!af_legal_f(DEPTH, AF_LEVEL)) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
  end
  if (!ae_legal_f(DEPTH, AE_LEVEL)) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_n;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [CNT_W-1:0]  count_n;
  logic              wr_acc;
  logic              rd_acc;
  logic              ram_we;
  logic [PTR_W-1:0]  ram_raddr;
  logic [DATA_W-1:0] ram_q;

  // Accept decisions use only registered flags, so no request-to-flag path exists;
  // a write into a full FIFO is allowed when the same edge pops a word.
  always_comb begin
    rd_acc   = rd_en & ~empty;
    wr_acc   = wr_en & (~full | rd_acc);
    wr_ptr_n = wr_acc ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n = rd_acc ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n  = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  // Nothing is stored during the reset cycle.
  assign ram_we = wr_acc & ~rst;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W),
    .REG_RD (0)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // Pointers, occupancy and flags, all derived from the next occupancy value.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      full         <= (count_n == DEPTH_C);
      empty        <= (count_n == '0);
      almost_full  <= (count_n >= AF_C);
      almost_empty <= (count_n <= AE_C);
    end
  end

  // Sticky error flags; a new rejection in the clearing cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & ~wr_acc) | (overflow & ~err_clr);
      underflow <= (rd_en & ~rd_acc) | (underflow & ~err_clr);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // The head register tracks the word at the post-edge read pointer; the
    // array is looked up at rd_ptr_n, and bypassed when that slot is being
    // written on this same edge (the incoming word becomes the only entry).
    assign ram_raddr = rd_ptr_n;
    assign rd_valid  = ~empty;

    // Head register load; holds while the FIFO drains to empty.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data <= '0;
      end else if (count_n != '0) begin
        rd_data <= (wr_acc && (wr_ptr == rd_ptr_n)) ? wr_data : ram_q;
      end
    end
  end else begin : g_std
    assign ram_raddr = rd_ptr;

    // Registered read: an accepted pop presents the head word after the edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-mode and one FWFT-mode instance
// share stimulus and are checked against a queue-based reference model.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       err_clr;

  logic [7:0] s_rdd, f_rdd;
  logic       s_rdv, f_rdv;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] s_cnt, f_cnt;
  logic [9:0] s_st, f_st;

  assign s_st = {s_full, s_empty, s_af, s_ae, s_cnt, s_ovf, s_udf};
  assign f_st = {f_full, f_empty, f_af, f_ae, f_cnt, f_ovf, f_udf};

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rdd), .rd_valid(s_rdv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf), .err_clr(err_clr));

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rdd), .rd_valid(f_rdv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf), .err_clr(err_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: queue of stored words plus error and read-port state.
  logic [7:0] q[$];
  bit         m_ovf, m_udf, m_rdv;
  logic [7:0] m_rdd;

  function automatic logic [9:0] exp_st();
    int sz;
    sz = q.size();
    return {sz == 8, sz == 0, sz >= 7, sz <= 1, 4'(sz), m_ovf, m_udf};
  endfunction

  // Drive one clock cycle of inputs, advance the model, settle past the edge.
  task automatic cycle(input bit r_st, input bit w, input logic [7:0] d,
                       input bit r, input bit c);
    int sz;
    bit racc, wacc;
    rst = r_st; wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    @(posedge clk);
    sz = q.size();
    if (r_st) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rdv = 0; m_rdd = 8'h00;
    end else begin
      racc = r && (sz != 0);
      wacc = w && ((sz != 8) || racc);
      if (racc) begin m_rdd = q.pop_front(); m_rdv = 1; end
      else m_rdv = 0;
      if (wacc) q.push_back(d);
      m_ovf = (w && !wacc) || (m_ovf && !c);
      m_udf = (r && !racc) || (m_udf && !c);
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 8'h00, 0, 0);
    cycle(1, 0, 8'h00, 0, 0);
    n_chk++; if (s_st !== 10'b01_01_0000_00) begin n_fail++; $display("FAIL reset_status: got %b want %b", s_st, 10'b01_01_0000_00); end
    n_chk++; if (f_st !== 10'b01_01_0000_00) begin n_fail++; $display("FAIL reset_status_fwft: got %b want %b", f_st, 10'b01_01_0000_00); end
    n_chk++; if ({s_rdv, s_rdd, f_rdv, f_rdd} !== 18'd0) begin n_fail++; $display("FAIL reset_rdport: got %b%h %b%h want all zero", s_rdv, s_rdd, f_rdv, f_rdd); end
  endtask

  task automatic test_fill_drain();
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, 8'(i), 0, 0);
      n_chk++; if (s_st !== exp_st()) begin n_fail++; $display("FAIL fill_status[%0d]: got %b want %b", i, s_st, exp_st()); end
    end
    n_chk++; if ({s_full, s_cnt, s_af} !== {1'b1, 4'd8, 1'b1}) begin n_fail++; $display("FAIL fill_full: got full=%b count=%0d af=%b want 1 8 1", s_full, s_cnt, s_af); end
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 8'h00, 1, 0);
      n_chk++; if ({s_rdv, s_rdd} !== {1'b1, 8'(i)}) begin n_fail++; $display("FAIL drain_data[%0d]: got v=%b d=%h want v=1 d=%h", i, s_rdv, s_rdd, 8'(i)); end
      n_chk++; if (s_st !== exp_st()) begin n_fail++; $display("FAIL drain_status[%0d]: got %b want %b", i, s_st, exp_st()); end
    end
    cycle(0, 0, 8'h00, 0, 0);
    n_chk++; if ({s_rdv, s_empty, s_ovf, s_udf} !== 4'b0100) begin n_fail++; $display("FAIL drain_end: got rdv=%b empty=%b ovf=%b udf=%b want 0 1 0 0", s_rdv, s_empty, s_ovf, s_udf); end
  endtask

  task automatic test_errors();
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++) cycle(0, 1, 8'(8'h20 + i), 0, 0);
    cycle(0, 1, 8'hEE, 0, 0);
    n_chk++; if ({s_ovf, s_cnt, s_full} !== {1'b1, 4'd8, 1'b1}) begin n_fail++; $display("FAIL overflow_set: got ovf=%b count=%0d full=%b want 1 8 1", s_ovf, s_cnt, s_full); end
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 8'h00, 1, 0);
      n_chk++; if (s_rdd !== 8'(8'h20 + i)) begin n_fail++; $display("FAIL overflow_mem[%0d]: got %h want %h", i, s_rdd, 8'(8'h20 + i)); end
    end
    cycle(0, 0, 8'h00, 1, 0);
    n_chk++; if ({s_udf, s_ovf, s_rdv, s_cnt} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin n_fail++; $display("FAIL underflow_set: got udf=%b ovf=%b rdv=%b count=%0d want 1 1 0 0", s_udf, s_ovf, s_rdv, s_cnt); end
    cycle(0, 0, 8'h00, 1, 1);
    n_chk++; if ({s_ovf, s_udf} !== 2'b01) begin n_fail++; $display("FAIL set_beats_clear: got ovf=%b udf=%b want 0 1", s_ovf, s_udf); end
    cycle(0, 0, 8'h00, 0, 1);
    n_chk++; if ({s_ovf, s_udf, f_ovf, f_udf} !== 4'b0000) begin n_fail++; $display("FAIL err_clr: got %b%b%b%b want 0000", s_ovf, s_udf, f_ovf, f_udf); end
  endtask

  task automatic test_simultaneous();
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++) cycle(0, 1, 8'(8'h10 + i), 0, 0);
    cycle(0, 1, 8'h99, 1, 0);
    n_chk++; if ({s_cnt, s_full, s_ovf, s_rdv, s_rdd} !== {4'd8, 1'b1, 1'b0, 1'b1, 8'h11}) begin n_fail++; $display("FAIL both_full: got count=%0d full=%b ovf=%b rdv=%b d=%h want 8 1 0 1 11", s_cnt, s_full, s_ovf, s_rdv, s_rdd); end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 8'h00, 1, 0);
      n_chk++; if ({s_rdv, s_rdd} !== {m_rdv, m_rdd}) begin n_fail++; $display("FAIL both_full_order[%0d]: got %b %h want %b %h", i, s_rdv, s_rdd, m_rdv, m_rdd); end
    end
    n_chk++; if (m_rdd !== 8'h99) begin n_fail++; $display("FAIL both_full_last: got %h want 99", m_rdd); end
    cycle(1, 0, 8'h00, 0, 0);
    cycle(0, 1, 8'h42, 1, 0);
    n_chk++; if ({s_cnt, s_udf, s_rdv} !== {4'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL both_empty: got count=%0d udf=%b rdv=%b want 1 1 0", s_cnt, s_udf, s_rdv); end
    cycle(0, 0, 8'h00, 1, 0);
    n_chk++; if ({s_rdv, s_rdd} !== {1'b1, 8'h42}) begin n_fail++; $display("FAIL both_empty_data: got %b %h want 1 42", s_rdv, s_rdd); end
  endtask

  task automatic test_wrap();
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'(8'h30 + i), 0, 0);
    for (int k = 0; k < 20; k++) begin
      cycle(0, 1, 8'($urandom_range(0, 255)), 0, 0);
      n_chk++; if ({s_cnt, s_st} !== {4'd4, exp_st()}) begin n_fail++; $display("FAIL wrap_wr[%0d]: got count=%0d st=%b want 4 %b", k, s_cnt, s_st, exp_st()); end
      cycle(0, 0, 8'h00, 1, 0);
      n_chk++; if ({s_cnt, s_rdv, s_rdd} !== {4'd3, 1'b1, m_rdd}) begin n_fail++; $display("FAIL wrap_rd[%0d]: got count=%0d v=%b d=%h want 3 1 %h", k, s_cnt, s_rdv, s_rdd, m_rdd); end
    end
  endtask

  task automatic test_fwft();
    cycle(1, 0, 8'h00, 0, 0);
    cycle(0, 1, 8'hA5, 0, 0);
    n_chk++; if ({f_rdv, f_rdd, s_rdv} !== {1'b1, 8'hA5, 1'b0}) begin n_fail++; $display("FAIL fwft_show: got v=%b d=%h std_v=%b want 1 a5 0", f_rdv, f_rdd, s_rdv); end
    cycle(0, 1, 8'h5A, 0, 0);
    n_chk++; if ({f_rdv, f_rdd} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL fwft_hold: got v=%b d=%h want 1 a5", f_rdv, f_rdd); end
    cycle(0, 0, 8'h00, 1, 0);
    n_chk++; if ({f_rdv, f_rdd} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL fwft_next: got v=%b d=%h want 1 5a", f_rdv, f_rdd); end
    cycle(0, 0, 8'h00, 1, 0);
    n_chk++; if ({f_empty, f_rdv} !== 2'b10) begin n_fail++; $display("FAIL fwft_pop: got empty=%b v=%b want 1 0", f_empty, f_rdv); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h50 + i), 0, 0);
    n_chk++; if (s_cnt !== 4'd5) begin n_fail++; $display("FAIL mid_pre: got count=%0d want 5", s_cnt); end
    cycle(1, 1, 8'h77, 0, 0);
    n_chk++; if ({s_st, f_st} !== {10'b01_01_0000_00, 10'b01_01_0000_00}) begin n_fail++; $display("FAIL mid_reset: got %b %b want reset state", s_st, f_st); end
    cycle(0, 0, 8'h00, 1, 0);
    n_chk++; if ({s_udf, s_rdv, s_cnt} !== {1'b1, 1'b0, 4'd0}) begin n_fail++; $display("FAIL mid_nowrite: got udf=%b rdv=%b count=%0d want 1 0 0", s_udf, s_rdv, s_cnt); end
  endtask

  task automatic test_random();
    cycle(1, 0, 8'h00, 0, 0);
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55),
            8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 15) == 0));
      n_chk++; if (s_st !== exp_st()) begin n_fail++; $display("FAIL rnd_status[%0d]: got %b want %b", k, s_st, exp_st()); end
      n_chk++; if ({s_rdv, s_rdd} !== {m_rdv, m_rdd}) begin n_fail++; $display("FAIL rnd_std_rd[%0d]: got %b %h want %b %h", k, s_rdv, s_rdd, m_rdv, m_rdd); end
      n_chk++; if (f_st !== exp_st()) begin n_fail++; $display("FAIL rnd_fwft_status[%0d]: got %b want %b", k, f_st, exp_st()); end
      n_chk++; if (f_rdv !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_fwft_valid[%0d]: got %b want %b", k, f_rdv, (q.size() != 0)); end
      if (q.size() != 0) begin
        n_chk++; if (f_rdd !== q[0]) begin n_fail++; $display("FAIL rnd_fwft_data[%0d]: got %h want %h", k, f_rdd, q[0]); end
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; err_clr = 1'b0;
    m_ovf = 0; m_udf = 0; m_rdv = 0; m_rdd = 8'h00;
    test_reset();
    test_fill_drain();
    test_errors();
    test_simultaneous();
    test_wrap();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
